mem_stage_access: RTL and testbench
===================================

// Module: mem_stage_access
// PURPOSE
// - MEM-stage consumer of the EXE/MEM pipeline register outputs. Decodes the
//   memory bits of the control word and runs load/store transactions on a
//   req/ack data-memory port.
// - Stalls EXE/MEM (drives its active-high hold/EN) until the access completes.
// - Registers the result bundle toward MEM/WB.
// PARAMETERS
// - ADDR_W   16   data-memory address width; mem_addr = i_alu[ADDR_W-1:0]
// - TIMEOUT  255  max BUSY cycles without mem_ack (only with MEM_TIMEOUT_EN)
// PORTS
// - clk        in   1       single clock, all state on posedge
// - rst        in   1       synchronous, active-high reset
// - i_ctrl     in   16      ctrl word; [0]=mem_read, [1]=mem_write, [2]=reg_write
// - i_alu      in   32      ALU result: memory address, or pass-through result
// - i_srcReg   in   32      store data
// - i_srcRegDir in  4       destination register index
// - o_stall    out  1       hold for EXE/MEM EN (1 = hold)
// - mem_req    out  1       memory request, held until ack
// - mem_we     out  1       1 = write, 0 = read; valid while mem_req
// - mem_addr   out  ADDR_W  access address
// - mem_wdata  out  32      store data
// - mem_rdata  in   32      load data, valid with mem_ack
// - mem_ack    in   1       one-cycle completion strobe
// - o_ctrl     out  16      registered ctrl toward MEM/WB
// - o_result   out  32      registered load data or ALU pass-through
// - o_dstDir   out  4       registered destination index
// - o_valid    out  1       1-cycle pulse: o_* bundle is new
// - o_err      out  1       1-cycle timeout pulse (constant 0 without macro)
// BEHAVIOUR
// - Reset: state=IDLE. mem_req, mem_we, o_stall, o_valid, o_err = 0.
//   o_ctrl, o_result, o_dstDir, mem_addr, mem_wdata = 0.
// - States: IDLE, BUSY.
// - IDLE, no mem bit set: at the next edge, o_result<=i_alu, o_ctrl<=i_ctrl,
//   o_dstDir<=i_srcRegDir, o_valid<=1. Latency 1. o_stall=0.
// - IDLE, mem_read|mem_write: o_stall=1 combinationally in the same cycle.
//   Next edge: mem_req<=1, mem_we<=mem_write (write wins if both bits set),
//   addr/wdata latched, state->BUSY.
// - BUSY: mem_req, mem_we, mem_addr and mem_wdata are held stable.
//   o_stall = !mem_ack.
// - BUSY with mem_ack:
//   - o_stall drops that cycle, so EXE/MEM advances at the same edge.
//   - At that edge: mem_req<=0, state->IDLE, o_valid<=1, o_ctrl/o_dstDir from
//     the latched copy. o_result<=mem_rdata for a load, or the latched address
//     zero-extended for a store.
//   - Each access occupies at least 2 cycles; the instruction is never reissued.
// - mem_ack while in IDLE is ignored.
// - Inputs are sampled only in IDLE; they are latched at request issue.
// - rst asserted mid-BUSY: request abandoned, mem_req=0 next cycle, all
//   outputs return to reset values; a late mem_ack is ignored.
// CONFIGURATION
// - MEM_TIMEOUT_EN defined:
//   - An 8..16-bit counter clears on BUSY entry and increments each BUSY cycle.
//   - When it reaches TIMEOUT without ack: mem_req<=0, state->IDLE,
//     o_err pulses 1, o_valid pulses 1, o_result<=0, o_ctrl[2] cleared
//     (no register write), o_stall released that cycle.
// - MEM_TIMEOUT_EN undefined:
//   - No counter. BUSY waits indefinitely. o_err tied 0.
// TESTING
// - Reset: rst=1 for 2 cycles with mem_ack toggling -> all outputs 0,
//   mem_req never 1.
// - ALU pass-through: i_ctrl=16'h0004, i_alu=32'h1234 -> next cycle
//   o_result=32'h1234, o_valid=1; o_stall stays 0.
// - Load, ack 3 cycles after req: i_ctrl=16'h0005, i_alu=32'h0040,
//   mem_rdata=32'hCAFE0001 -> mem_addr=16'h0040, mem_we=0.
//   o_stall=1 until the ack cycle; next cycle o_result=32'hCAFE0001, o_valid=1.
// - Store with both bits set: i_ctrl=16'h0003, i_srcReg=32'hA5A5A5A5 ->
//   mem_we=1, mem_wdata=32'hA5A5A5A5; ack same cycle as req -> o_valid next cycle.
// - Reset mid-BUSY, then a stray ack: mem_req=0 after the reset edge,
//   o_valid stays 0.
// - MEM_TIMEOUT_EN with TIMEOUT=4, no ack -> mem_req drops after 4 BUSY cycles,
//   o_err=1 for one cycle, o_result=0, o_ctrl[2]=0.

Source files
------------

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM-stage consumer of the EXE/MEM pipeline register.
// Decodes the memory bits of the control word, runs one load or store on a
// req/ack data-memory port, holds EXE/MEM while the access is outstanding,
// and registers the result bundle toward MEM/WB.
// Optional feature macro: MEM_TIMEOUT_EN (BUSY watchdog, drives o_err).
module mem_stage_access #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       i_ctrl,
  input  logic [31:0]       i_alu,
  input  logic [31:0]       i_srcReg,
  input  logic [3:0]        i_srcRegDir,
  output logic              o_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       o_ctrl,
  output logic [31:0]       o_result,
  output logic [3:0]        o_dstDir,
  output logic              o_valid,
  output logic              o_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  // Copy of the instruction's control/destination taken at request issue,
  // so EXE/MEM contents are not needed once the access is in flight.
  logic [15:0]         ctrl_lat_q, ctrl_lat_d;
  logic [3:0]          dst_lat_q, dst_lat_d;
  logic [15:0]         o_ctrl_q, o_ctrl_d;
  logic [31:0]         o_result_q, o_result_d;
  logic [3:0]          o_dst_q, o_dst_d;
  logic                o_valid_q, o_valid_d;
  logic                mem_op;
  logic                timeout_hit;

`ifdef MEM_TIMEOUT_EN
  // Counter only has to reach TIMEOUT-1; kept within 8..16 bits.
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                o_err_q, o_err_d;

  // Fires in the TIMEOUT-th BUSY cycle that has not seen an ack.
  assign timeout_hit = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign o_err       = o_err_q;
`else
  assign timeout_hit = 1'b0;
  assign o_err       = 1'b0;
`endif

  assign mem_op    = i_ctrl[0] | i_ctrl[1];
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign o_ctrl    = o_ctrl_q;
  assign o_result  = o_result_q;
  assign o_dstDir  = o_dst_q;
  assign o_valid   = o_valid_q;

  // Next-state, result bundle and stall decode.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ctrl_lat_d = ctrl_lat_q;
    dst_lat_d  = dst_lat_q;
    o_ctrl_d   = o_ctrl_q;
    o_result_d = o_result_q;
    o_dst_d    = o_dst_q;
    o_valid_d  = 1'b0;
    o_stall    = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    o_err_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          // Hold EXE/MEM immediately; the request goes out at the next edge.
          o_stall    = 1'b1;
          state_d    = BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = i_ctrl[1];
          addr_d     = i_alu[ADDR_W-1:0];
          wdata_d    = i_srcReg;
          ctrl_lat_d = i_ctrl;
          dst_lat_d  = i_srcRegDir;
`ifdef MEM_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end else begin
          o_result_d = i_alu;
          o_ctrl_d   = i_ctrl;
          o_dst_d    = i_srcRegDir;
          o_valid_d  = 1'b1;
        end
      end

      BUSY: begin
`ifdef MEM_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (mem_ack) begin
          // Releasing stall now lets EXE/MEM advance on the completion edge.
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          o_valid_d  = 1'b1;
          o_ctrl_d   = ctrl_lat_q;
          o_dst_d    = dst_lat_q;
          o_result_d = mem_we_q ? 32'(addr_q) : mem_rdata;
        end else if (timeout_hit) begin
          // Abandon the access and suppress the register write.
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          o_valid_d  = 1'b1;
          o_ctrl_d   = ctrl_lat_q & ~16'h0004;
          o_dst_d    = dst_lat_q;
          o_result_d = '0;
`ifdef MEM_TIMEOUT_EN
          o_err_d    = 1'b1;
`endif
        end else begin
          o_stall = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (rst) begin
      o_stall = 1'b0;
    end
  end

  // State, memory-port and result registers; reset returns everything to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_lat_q <= '0;
      dst_lat_q  <= '0;
      o_ctrl_q   <= '0;
      o_result_q <= '0;
      o_dst_q    <= '0;
      o_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ctrl_lat_q <= ctrl_lat_d;
      dst_lat_q  <= dst_lat_d;
      o_ctrl_q   <= o_ctrl_d;
      o_result_q <= o_result_d;
      o_dst_q    <= o_dst_d;
      o_valid_q  <= o_valid_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Watchdog counter and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      o_err_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      o_err_q <= o_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: directed scenarios plus randomized traffic checked
// against a transaction-level reference model of the MEM stage.
module tb_mem_stage_access;

  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_ctrl;
  logic [31:0] i_alu;
  logic [31:0] i_srcReg;
  logic [3:0]  i_srcRegDir;
  logic        o_stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] o_ctrl;
  logic [31:0] o_result;
  logic [3:0]  o_dstDir;
  logic        o_valid;
  logic        o_err;

  always #5 clk = ~clk;

  mem_stage_access #(.ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_ctrl(i_ctrl), .i_alu(i_alu),
    .i_srcReg(i_srcReg), .i_srcRegDir(i_srcRegDir), .o_stall(o_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .o_ctrl(o_ctrl), .o_result(o_result), .o_dstDir(o_dstDir),
    .o_valid(o_valid), .o_err(o_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one pending transaction plus the expected outputs.
  bit          m_busy;
  int          m_cycles;
  bit          p_we;
  logic [15:0] p_addr;
  logic [31:0] p_wdata;
  logic [15:0] p_ctrl;
  logic [3:0]  p_dst;
  logic        e_req, e_valid, e_err;
  logic [15:0] e_ctrl;
  logic [31:0] e_result;
  logic [3:0]  e_dst;

  function automatic logic exp_stall();
    if (rst) return 1'b0;
    if (!m_busy) return i_ctrl[0] | i_ctrl[1];
    if (mem_ack) return 1'b0;
    if (TO_EN && (m_cycles + 1 == TO)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_busy = 0; m_cycles = 0; e_req = 0; e_valid = 0; e_err = 0;
      e_ctrl = '0; e_result = '0; e_dst = '0; p_we = 0; p_addr = '0;
      p_wdata = '0;
    end else if (!m_busy) begin
      e_valid = 0; e_err = 0;
      if (i_ctrl[0] || i_ctrl[1]) begin
        m_busy = 1; m_cycles = 0; e_req = 1;
        p_we = i_ctrl[1]; p_addr = i_alu[15:0]; p_wdata = i_srcReg;
        p_ctrl = i_ctrl; p_dst = i_srcRegDir;
      end else begin
        e_result = i_alu; e_ctrl = i_ctrl; e_dst = i_srcRegDir; e_valid = 1;
      end
    end else begin
      e_valid = 0; e_err = 0;
      m_cycles++;
      if (mem_ack) begin
        m_busy = 0; e_req = 0; e_valid = 1; e_ctrl = p_ctrl; e_dst = p_dst;
        e_result = p_we ? {16'h0, p_addr} : mem_rdata;
      end else if (TO_EN && m_cycles == TO) begin
        m_busy = 0; e_req = 0; e_valid = 1; e_err = 1; e_result = 0;
        e_ctrl = p_ctrl & 16'hFFFB; e_dst = p_dst;
      end
    end
  endtask

  // One clock: combinational stall check, model advance, registered checks.
  task automatic step();
    #1;
    check("o_stall", 32'(o_stall), 32'(exp_stall()));
    model_update();
    @(posedge clk);
    #1;
    check("mem_req", 32'(mem_req), 32'(e_req));
    check("o_valid", 32'(o_valid), 32'(e_valid));
    check("o_err", 32'(o_err), 32'(e_err));
    check("o_result", o_result, e_result);
    check("o_ctrl", 32'(o_ctrl), 32'(e_ctrl));
    check("o_dstDir", 32'(o_dstDir), 32'(e_dst));
    if (e_req) begin
      check("mem_we", 32'(mem_we), 32'(p_we));
      check("mem_addr", 32'(mem_addr), 32'(p_addr));
      check("mem_wdata", mem_wdata, p_wdata);
    end
  endtask

  initial begin
    m_busy = 0; m_cycles = 0; e_req = 0; e_valid = 0; e_err = 0;
    e_ctrl = '0; e_result = '0; e_dst = '0;
    p_we = 0; p_addr = '0; p_wdata = '0; p_ctrl = '0; p_dst = '0;
    rst = 1; i_ctrl = '0; i_alu = '0; i_srcReg = '0; i_srcRegDir = '0;
    mem_rdata = '0; mem_ack = 0;

    // Reset with a toggling ack.
    for (int i = 0; i < 2; i++) begin
      mem_ack = i[0];
      step();
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_result", o_result, 32'd0);
    end
    rst = 0; mem_ack = 0;

    // ALU pass-through.
    i_ctrl = 16'h0004; i_alu = 32'h1234; i_srcRegDir = 4'd3;
    step();
    check("pt_result", o_result, 32'h1234);
    check("pt_valid", 32'(o_valid), 32'd1);

    // Load acked in the third request cycle.
    i_ctrl = 16'h0005; i_alu = 32'h0040; i_srcReg = 32'h0BAD0BAD;
    i_srcRegDir = 4'd5; mem_rdata = 32'hCAFE0001;
    step();
    check("ld_addr", 32'(mem_addr), 32'h0040);
    check("ld_we", 32'(mem_we), 32'd0);
    step();
    step();
    mem_ack = 1;
    step();
    mem_ack = 0;
    check("ld_result", o_result, 32'hCAFE0001);
    check("ld_valid", 32'(o_valid), 32'd1);

    // Store with both bits set, acked in the first request cycle.
    i_ctrl = 16'h0003; i_alu = 32'h0001_0080; i_srcReg = 32'hA5A5A5A5;
    i_srcRegDir = 4'd9;
    step();
    check("st_we", 32'(mem_we), 32'd1);
    check("st_wdata", mem_wdata, 32'hA5A5A5A5);
    mem_ack = 1;
    step();
    mem_ack = 0;
    check("st_valid", 32'(o_valid), 32'd1);
    check("st_result", o_result, 32'h0000_0080);

    // Reset mid-BUSY, then a stray ack while reset is still held.
    i_ctrl = 16'h0001; i_alu = 32'h0100;
    step();
    step();
    rst = 1;
    step();
    check("rb_req", 32'(mem_req), 32'd0);
    mem_ack = 1;
    step();
    check("rb_req2", 32'(mem_req), 32'd0);
    check("rb_valid", 32'(o_valid), 32'd0);
    rst = 0; mem_ack = 0; i_ctrl = 16'h0000;
    step();

`ifdef MEM_TIMEOUT_EN
    // Watchdog: no ack ever arrives.
    i_ctrl = 16'h0005; i_alu = 32'h0200; i_srcRegDir = 4'd7;
    step();
    for (int i = 0; i < TO; i++) step();
    check("to_err", 32'(o_err), 32'd1);
    check("to_req", 32'(mem_req), 32'd0);
    check("to_result", o_result, 32'd0);
    check("to_ctrl2", 32'(o_ctrl[2]), 32'd0);
    i_ctrl = 16'h0000;
    step();
    check("to_err_end", 32'(o_err), 32'd0);
`endif

    // Randomized traffic, inputs also change while an access is in flight.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      i_ctrl      = 16'($urandom);
      i_alu       = $urandom;
      i_srcReg    = $urandom;
      i_srcRegDir = 4'($urandom);
      mem_rdata   = $urandom;
      mem_ack     = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
